// File: rtl/fifo_ctrl_pkg.sv
// Shared FIFO constants and controller state encoding used by the
// pointer datapath, the controller and its testbench.
package fifo_ctrl_pkg;

  localparam int FIFO_DEPTH  = 8;
  localparam int FIFO_ADDR_W = 3;
  localparam int FIFO_CNT_W  = FIFO_ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } fifo_state_e;

  // Occupancy needs one extra bit so that "exactly DEPTH" is representable.
  function automatic int cnt_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage : fifo_ctrl_pkg

// File: rtl/fifo_ctrl_if.sv
// Request/acknowledge and status bundle between a FIFO user (master)
// and the fifo_ctrl pointer/occupancy controller (slave).
interface fifo_ctrl_if
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = FIFO_ADDR_W
) ();

  logic              wr_req;
  logic              rd_req;
  logic              wr_ack;
  logic              rd_ack;
  logic [DEPTH-1:0]  wr_load;
  logic [ADDR_W-1:0] rd_sel;
  logic [ADDR_W-1:0] wr_adr;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              ovf;
  logic              udf;
  fifo_state_e       state;

  modport master (
    output wr_req, rd_req,
    input  wr_ack, rd_ack, wr_load, rd_sel, wr_adr, count,
    input  full, empty, ovf, udf, state
  );

  modport slave (
    input  wr_req, rd_req,
    output wr_ack, rd_ack, wr_load, rd_sel, wr_adr, count,
    output full, empty, ovf, udf, state
  );

endinterface : fifo_ctrl_if

// File: rtl/fifo_ctrl_ptr.sv
// Enable-gated wrapping pointer; wraps DEPTH-1 -> 0 naturally because
// DEPTH is exactly 2**ADDR_W.
module fifo_ptr #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  output logic [ADDR_W-1:0] ptr_o
);

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;

  // NOTE: default first so every path assigns ptr_d and no latch is inferred.
  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = ptr_q + ADDR_W'(1);
    end
  end

  // NOTE: non-blocking here so all registers see pre-edge values together.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule : fifo_ptr

// File: rtl/fifo_ctrl.sv
// FIFO controller: accept/reject decisions, one-hot slot load decode,
// occupancy count, sticky overflow/underflow flags and EMPTY/PARTIAL/FULL FSM.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic        clk,
  input  logic        reset,
  fifo_ctrl_if.slave  bus
);

  localparam int                CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEPTH - 1);

  if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
    $error("fifo_ctrl: DEPTH must equal 2**ADDR_W");
  end

  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  fifo_state_e       state_q, state_d;

  logic              full;
  logic              empty;
  logic              wr_ack;
  logic              rd_ack;
  logic [ADDR_W-1:0] wr_adr;
  logic [ADDR_W-1:0] rd_sel;
  logic [DEPTH-1:0]  wr_load;

  // Flags come from registered occupancy only, so requests never feed them.
  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  assign wr_ack = bus.wr_req && !full  && !reset;
  assign rd_ack = bus.rd_req && !empty && !reset;

  fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .en_i  (wr_ack),
    .ptr_o (wr_adr)
  );

  fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .en_i  (rd_ack),
    .ptr_o (rd_sel)
  );

  always_comb begin
    wr_load = '0;
    if (wr_ack) begin
      wr_load[wr_adr] = 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({wr_ack, rd_ack})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q || (bus.wr_req && full);
    udf_d = udf_q || (bus.rd_req && empty);
  end

  // Only a single-sided accept moves occupancy, hence the FSM edges.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (wr_ack && !rd_ack) state_d = ST_PARTIAL;
      end
      ST_PARTIAL: begin
        if (wr_ack && !rd_ack && count_q == CNT_LAST) begin
          state_d = ST_FULL;
        end else if (rd_ack && !wr_ack && count_q == CNT_W'(1)) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (rd_ack && !wr_ack) state_d = ST_PARTIAL;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // NOTE: only control state is reset; slot storage lives outside and keeps its data.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      state_q <= ST_EMPTY;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      state_q <= state_d;
    end
  end

  assign bus.wr_ack  = wr_ack;
  assign bus.rd_ack  = rd_ack;
  assign bus.wr_load = wr_load;
  assign bus.rd_sel  = rd_sel;
  assign bus.wr_adr  = wr_adr;
  assign bus.count   = count_q;
  assign bus.full    = full;
  assign bus.empty   = empty;
  assign bus.ovf     = ovf_q;
  assign bus.udf     = udf_q;
  assign bus.state   = state_q;

endmodule : fifo_ctrl

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter DEPTH, default 8: number of storage slots; SHALL be 2**ADDR_W.
REQ-002 Parameter ADDR_W, default 3: pointer width.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wr_req  input  1  write request, one entry per cycle.
REQ-006 rd_req  input  1  read request, one entry per cycle.
REQ-007 wr_load  output  DEPTH  one-hot load enable to storage slots; combinational.
REQ-008 rd_sel  output  ADDR_W  read mux select (current read pointer); registered.
REQ-009 wr_adr  output  ADDR_W  current write pointer; registered.
REQ-010 count  output  ADDR_W+1  occupancy, 0..DEPTH; registered.
REQ-011 full  output  1  high when count == DEPTH.
REQ-012 empty  output  1  high when count == 0.
REQ-013 wr_ack / rd_ack  output  1 each  combinational: request accepted this cycle.
REQ-014 ovf / udf  output  1 each  sticky error flags: rejected write / rejected read.

Function
REQ-015 Write accepted (wr_ack=1) iff wr_req && !full; read accepted (rd_ack=1) iff rd_req && !empty.
REQ-016 wr_load SHALL equal one-hot decode of wr_adr when wr_ack=1, else all zeros.
REQ-017 On accepted write, wr_adr SHALL increment by 1 at next edge, wrapping DEPTH-1 -> 0.
REQ-018 On accepted read, rd_sel SHALL increment by 1 at next edge, wrapping DEPTH-1 -> 0.
REQ-019 count: +1 on write-only accept, -1 on read-only accept, unchanged on both or neither.
REQ-020 Read data for an accepted read SHALL be valid on the storage mux during the accept cycle (zero-latency read select); written data visible to a read one cycle after the write accept.
REQ-021 Full with wr_req && rd_req: read accepted, write rejected, count -> DEPTH-1, ovf set.
REQ-022 Empty with wr_req && rd_req: write accepted, read rejected, count -> 1, udf set.
REQ-023 Neither flag SHALL ever cause a pointer or count change; count SHALL never exceed DEPTH or go below 0.
REQ-024 ovf SHALL set on any cycle with wr_req && full; udf on any cycle with rd_req && empty; both hold until reset.
REQ-025 full and empty SHALL be derived from registered count only (no combinational path from requests).
REQ-026 Controller states: EMPTY (count=0), PARTIAL, FULL (count=DEPTH); transitions only via REQ-019.

Reset
REQ-027 reset high at a rising edge SHALL force wr_adr=0, rd_sel=0, count=0, ovf=0, udf=0; thus empty=1, full=0.
REQ-028 Reset SHALL take priority over any simultaneous request; wr_ack, rd_ack, wr_load SHALL be 0 while reset is high.
REQ-029 Reset mid-operation SHALL discard all occupancy; storage contents not cleared by this block.

Structure
REQ-030 DEPTH, ADDR_W and derived count width SHALL live in a shared FIFO constants header used by datapath and controller.
REQ-031 One sub-module, fifo_ptr (enable-gated wrapping ADDR_W-bit counter with sync reset), SHALL be instantiated twice (write, read).
REQ-032 Slot decode and count/flag logic SHALL be in fifo_ctrl itself.

Verification
REQ-033 Reset, then 8 writes, no reads -> wr_load walks 0x01..0x80, count=8, full=1, wr_adr=0.
REQ-034 From full, 9th write -> wr_ack=0, wr_load=0x00, ovf=1, count stays 8.
REQ-035 From full, wr_req=rd_req=1 -> rd_ack=1, wr_ack=0, count=7, rd_sel=1.
REQ-036 From empty, wr_req=rd_req=1 -> wr_ack=1, rd_ack=0, udf=1, count=1.
REQ-037 Count=3, wr_adr=6, rd_sel=3, 4 cycles simultaneous accepts -> count stays 3, wr_adr=2, rd_sel=7 (wrap).
REQ-038 Count=5 with ovf=1, assert reset one cycle alongside wr_req -> count=0, empty=1, ovf=0, wr_load=0x00 during reset.
